// File: rtl/snk68_mem_pkg.sv
// rtl/snk68_mem_pkg.sv - shared types and constants for the ROM port arbiter
//
// Purpose : arbiter FSM state, grant owner type, default region bases on the
//           memory port and ROM region address widths.
// Ports   : none (package).

package snk68_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_M68K = 2'd1,
      ST_Z80  = 2'd2
   } arb_state_t;

   typedef enum logic {
      GR_M68K = 1'b0,
      GR_Z80  = 1'b1
   } grant_t;

   localparam logic [23:0] M68K_ROM_BASE_DEF  = 24'h000000;
   localparam logic [23:0] M68K_ROM2_BASE_DEF = 24'h020000;
   localparam logic [23:0] Z80_ROM_BASE_DEF   = 24'h040000;

   // Word-address bits taken from each CPU for its ROM region.
   localparam int M68K_ROM_AW = 17;
   localparam int Z80_ROM_AW  = 15;

endpackage

// File: rtl/z80_rom_line_buf.sv
// rtl/z80_rom_line_buf.sv - one-word Z80 ROM line buffer with hit compare
//
// Purpose : holds the last ROM word fetched for the Z80 so the second byte of
//           a word is served without a memory cycle.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           load, load_data - write the word and tag (tag from addr)
//           addr, cs        - current Z80 address and ROM select
//           hit             - buffer holds the word addressed by addr
//           rom_data        - selected byte while cs, else last byte shown

module z80_rom_line_buf
   import snk68_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_data,
   input  logic [15:0] addr,
   input  logic        cs,
   output logic        hit,
   output logic [7:0]  rom_data
);

   logic [Z80_ROM_AW-1:0] tag;
   logic                  tag_valid;
   logic [15:0]           line;
   logic [7:0]            held;
   logic [7:0]            sel_byte;

   assign hit      = tag_valid && (tag == addr[15:1]);
   assign sel_byte = addr[0] ? line[15:8] : line[7:0];
   // The Z80 bus keeps showing the last byte once the select is released.
   assign rom_data = cs ? sel_byte : held;

   always_ff @(posedge clk) begin
      if (reset) begin
         tag       <= '0;
         tag_valid <= 1'b0;
         line      <= '0;
         held      <= '0;
      end else begin
         if (load) begin
            tag       <= addr[15:1];
            tag_valid <= 1'b1;
            line      <= load_data;
         end
         if (cs) begin
            held <= sel_byte;
         end
      end
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares one 16-bit ROM port between 68k and Z80
//
// Purpose : round-robin arbitration of 68k program ROM and Z80 sound ROM
//           fetches onto a single request/ack memory port.
// Ports   : clk, reset                        - clock, sync active-high reset
//           m68k_rom_cs, m68k_rom_2_cs, m68k_a - 68k selects and word address
//           m68k_rom_data, m68k_rom_valid      - 68k read data and data valid
//           z80_rom_cs, z80_addr               - Z80 select and address
//           z80_rom_data, z80_wait_n           - Z80 read byte and WAIT_n
//           mem_addr, mem_req                  - memory port word address/request
//           mem_ack, mem_data                  - memory port ack pulse and data

module rom_port_arbiter
   import snk68_mem_pkg::*;
#(
   parameter logic [23:0] M68K_ROM_BASE  = M68K_ROM_BASE_DEF,
   parameter logic [23:0] M68K_ROM2_BASE = M68K_ROM2_BASE_DEF,
   parameter logic [23:0] Z80_ROM_BASE   = Z80_ROM_BASE_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        m68k_rom_cs,
   input  logic        m68k_rom_2_cs,
   input  logic [23:1] m68k_a,
   output logic [15:0] m68k_rom_data,
   output logic        m68k_rom_valid,
   input  logic        z80_rom_cs,
   input  logic [15:0] z80_addr,
   output logic [7:0]  z80_rom_data,
   output logic        z80_wait_n,
   output logic [23:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [15:0] mem_data
);

   arb_state_t  state;
   grant_t      last_grant;
   logic        m68k_cs_any;
   logic        m68k_cs_q;
   logic        z80_cs_q;
   logic        m68k_pend;
   logic        z80_pend;
   logic        m68k_edge;
   logic        z80_edge;
   logic        z80_hit;
   logic        ack_m68k;
   logic        ack_z80;
   logic [23:0] m68k_addr_map;
   logic [23:0] z80_addr_map;
   logic        unused_m68k_a;

   // The ROM regions only decode the low 17 word-address bits.
   assign unused_m68k_a = &{1'b0, m68k_a[23:M68K_ROM_AW+1]};

   assign m68k_cs_any = m68k_rom_cs | m68k_rom_2_cs;
   assign m68k_edge   = m68k_cs_any & ~m68k_cs_q;
   // A Z80 fetch that hits the line buffer never reaches the memory port.
   assign z80_edge    = z80_rom_cs & ~z80_cs_q & ~z80_hit;

   // Acks are only honoured while a transaction is outstanding.
   assign ack_m68k = mem_ack && (state == ST_M68K);
   assign ack_z80  = mem_ack && (state == ST_Z80);

   assign m68k_addr_map = (m68k_rom_2_cs ? M68K_ROM2_BASE : M68K_ROM_BASE)
                        + {{(24-M68K_ROM_AW){1'b0}}, m68k_a[M68K_ROM_AW:1]};
   assign z80_addr_map  = Z80_ROM_BASE
                        + {{(24-Z80_ROM_AW){1'b0}}, z80_addr[15:1]};

   assign z80_wait_n = ~(z80_rom_cs & ~z80_hit);

   z80_rom_line_buf u_line_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (ack_z80),
      .load_data (mem_data),
      .addr      (z80_addr),
      .cs        (z80_rom_cs),
      .hit       (z80_hit),
      .rom_data  (z80_rom_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         last_grant     <= GR_Z80;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         m68k_pend      <= 1'b0;
         z80_pend       <= 1'b0;
         m68k_cs_q      <= 1'b0;
         z80_cs_q       <= 1'b0;
         m68k_rom_data  <= '0;
         m68k_rom_valid <= 1'b0;
      end else begin
         m68k_cs_q <= m68k_cs_any;
         z80_cs_q  <= z80_rom_cs;

         // A new request edge takes priority over the completing ack.
         if (m68k_edge) begin
            m68k_pend <= 1'b1;
         end else if (ack_m68k) begin
            m68k_pend <= 1'b0;
         end

         if (z80_edge) begin
            z80_pend <= 1'b1;
         end else if (ack_z80) begin
            z80_pend <= 1'b0;
         end

         // Data of a cycle the 68k already abandoned is dropped.
         if (ack_m68k && m68k_cs_any) begin
            m68k_rom_data  <= mem_data;
            m68k_rom_valid <= 1'b1;
         end else if (!m68k_cs_any) begin
            m68k_rom_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (m68k_pend && (!z80_pend || last_grant == GR_Z80)) begin
                  state    <= ST_M68K;
                  mem_req  <= 1'b1;
                  mem_addr <= m68k_addr_map;
               end else if (z80_pend) begin
                  state    <= ST_Z80;
                  mem_req  <= 1'b1;
                  mem_addr <= z80_addr_map;
               end
            end
            ST_M68K: begin
               if (mem_ack) begin
                  state      <= ST_IDLE;
                  mem_req    <= 1'b0;
                  last_grant <= GR_M68K;
               end
            end
            ST_Z80: begin
               if (mem_ack) begin
                  state      <= ST_IDLE;
                  mem_req    <= 1'b0;
                  last_grant <= GR_Z80;
               end
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter

module tb_rom_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m68k_rom_cs = 1'b0;
   logic        m68k_rom_2_cs = 1'b0;
   logic [23:1] m68k_a = '0;
   logic [15:0] m68k_rom_data;
   logic        m68k_rom_valid;
   logic        z80_rom_cs = 1'b0;
   logic [15:0] z80_addr = '0;
   logic [7:0]  z80_rom_data;
   logic        z80_wait_n;
   logic [23:0] mem_addr;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_data = '0;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;
   bit resp_en = 1'b0;

   // Behavioural model state
   bit          m_busy;
   bit          m_owner;      // 0 = 68k, 1 = Z80
   bit          m_last;       // 1 = Z80 served last
   bit          m_p68, m_pz;
   logic [23:0] m_addr;
   bit          m_valid;
   logic [15:0] m_data;
   bit          m_bufv;
   logic [14:0] m_buft;
   logic [15:0] m_bufd;
   logic [7:0]  m_held;
   bit          m_prev68, m_prevz;

   rom_port_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .m68k_rom_cs    (m68k_rom_cs),
      .m68k_rom_2_cs  (m68k_rom_2_cs),
      .m68k_a         (m68k_a),
      .m68k_rom_data  (m68k_rom_data),
      .m68k_rom_valid (m68k_rom_valid),
      .z80_rom_cs     (z80_rom_cs),
      .z80_addr       (z80_addr),
      .z80_rom_data   (z80_rom_data),
      .z80_wait_n     (z80_wait_n),
      .mem_addr       (mem_addr),
      .mem_req        (mem_req),
      .mem_ack        (mem_ack),
      .mem_data       (mem_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_with(input logic [15:0] d);
      mem_ack  = 1'b1;
      mem_data = d;
      step();
      mem_ack  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Model: compare this cycle's outputs, then advance to the next cycle.
   always @(negedge clk) begin
      logic       hit_m;
      logic [7:0] byte_m;
      logic       cs68;
      bit         was_busy;
      hit_m  = m_bufv && (m_buft == z80_addr[15:1]);
      byte_m = z80_addr[0] ? m_bufd[15:8] : m_bufd[7:0];
      cs68   = m68k_rom_cs | m68k_rom_2_cs;

      if (cmp_en) begin
         chk("mem_req", mem_req, m_busy);
         if (m_busy) chk("mem_addr", mem_addr, m_addr);
         chk("m68k_valid", m68k_rom_valid, m_valid);
         if (m_valid) chk("m68k_data", m68k_rom_data, m_data);
         chk("z80_wait_n", z80_wait_n, !(z80_rom_cs && !hit_m));
         chk("z80_data", z80_rom_data, z80_rom_cs ? byte_m : m_held);
      end

      if (reset) begin
         m_busy = 0; m_owner = 0; m_last = 1; m_p68 = 0; m_pz = 0;
         m_addr = '0; m_valid = 0; m_data = '0;
         m_bufv = 0; m_buft = '0; m_bufd = '0; m_held = '0;
         m_prev68 = 0; m_prevz = 0;
      end else begin
         was_busy = m_busy;
         if (!was_busy && (m_p68 || m_pz)) begin
            if (m_p68 && m_pz) m_owner = m_last ? 1'b0 : 1'b1;
            else               m_owner = m_pz;
            m_busy = 1;
            if (m_owner)
               m_addr = 24'h040000 + 24'(z80_addr >> 1);
            else
               m_addr = (m68k_rom_2_cs ? 24'h020000 : 24'h000000) + 24'(m68k_a[17:1]);
         end
         if (!cs68) m_valid = 0;
         if (was_busy && mem_ack) begin
            if (!m_owner) begin
               m_p68 = 0;
               if (cs68) begin
                  m_valid = 1;
                  m_data  = mem_data;
               end
            end else begin
               m_pz   = 0;
               m_bufv = 1;
               m_buft = z80_addr[15:1];
               m_bufd = mem_data;
            end
            m_last = m_owner;
            m_busy = 0;
         end
         if (cs68 && !m_prev68) m_p68 = 1;
         if (z80_rom_cs && !m_prevz && !hit_m) m_pz = 1;
         if (z80_rom_cs) m_held = byte_m;
         m_prev68 = cs68;
         m_prevz  = z80_rom_cs;
      end
   end

   // Memory responder: random ack latency plus occasional stray acks.
   initial begin
      forever begin
         step();
         if (resp_en) begin
            if (mem_ack) begin
               mem_ack = 1'b0;
            end else if (mem_req) begin
               if ($urandom_range(0, 2) == 0) begin
                  mem_ack  = 1'b1;
                  mem_data = 16'($urandom);
               end
            end else if ($urandom_range(0, 15) == 0) begin
               mem_ack  = 1'b1;
               mem_data = 16'($urandom);
            end
         end
      end
   end

   task automatic run_m68k(input int n);
      for (int i = 0; i < n; i++) begin
         bit ok;
         repeat ($urandom_range(0, 3)) step();
         m68k_a = 23'($urandom);
         if ($urandom_range(0, 1) == 1) m68k_rom_2_cs = 1'b1;
         else                           m68k_rom_cs   = 1'b1;
         ok = 0;
         for (int t = 0; t < 300 && !ok; t++) begin
            step();
            if (m68k_rom_valid) ok = 1;
         end
         chk("m68k_served", ok, 1);
         m68k_rom_cs   = 1'b0;
         m68k_rom_2_cs = 1'b0;
         step();
      end
   endtask

   task automatic run_z80(input int n);
      for (int i = 0; i < n; i++) begin
         bit ok;
         repeat ($urandom_range(0, 3)) step();
         z80_addr   = 16'h0400 + 16'($urandom_range(0, 7));
         z80_rom_cs = 1'b1;
         #1;
         ok = 0;
         for (int t = 0; t < 300 && !ok; t++) begin
            if (z80_wait_n) ok = 1;
            else            step();
         end
         chk("z80_served", ok, 1);
         step();
         z80_rom_cs = 1'b0;
         step();
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset();
      cmp_en = 1'b1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 24'h0);
      chk("rst_m68k_valid", m68k_rom_valid, 0);
      chk("rst_m68k_data", m68k_rom_data, 16'h0);
      chk("rst_z80_data", z80_rom_data, 8'h0);
      chk("rst_z80_wait_n", z80_wait_n, 1);

      // Single 68k fetch
      m68k_a = 23'h000400;
      m68k_rom_cs = 1'b1;
      step();
      chk("t1_req_n1", mem_req, 0);
      step();
      chk("t1_req_n2", mem_req, 1);
      chk("t1_addr", mem_addr, 24'h000400);
      repeat (4) step();
      ack_with(16'h4E71);
      chk("t1_valid", m68k_rom_valid, 1);
      chk("t1_data", m68k_rom_data, 16'h4E71);
      m68k_rom_cs = 1'b0;
      step();
      chk("t1_valid_clr", m68k_rom_valid, 0);
      step();

      // Z80 miss then hit on the odd byte
      z80_addr = 16'h1234;
      z80_rom_cs = 1'b1;
      step();
      chk("t2_wait_lo", z80_wait_n, 0);
      chk("t2_req_n1", mem_req, 0);
      step();
      chk("t2_req", mem_req, 1);
      chk("t2_addr", mem_addr, 24'h04091A);
      step();
      chk("t2_wait_lo2", z80_wait_n, 0);
      ack_with(16'hBBAA);
      chk("t2_wait_hi", z80_wait_n, 1);
      chk("t2_byte_lo", z80_rom_data, 8'hAA);
      z80_rom_cs = 1'b0;
      step();
      z80_addr = 16'h1235;
      z80_rom_cs = 1'b1;
      step();
      chk("t2_hit_wait", z80_wait_n, 1);
      chk("t2_byte_hi", z80_rom_data, 8'hBB);
      chk("t2_hit_noreq", mem_req, 0);
      step();
      chk("t2_hit_noreq2", mem_req, 0);
      z80_rom_cs = 1'b0;
      step();

      // Simultaneous requests and round-robin
      do_reset();
      m68k_a = 23'h000010; m68k_rom_cs = 1'b1;
      z80_addr = 16'h0200; z80_rom_cs = 1'b1;
      step();
      step();
      chk("t3_first_68k", mem_addr, 24'h000010);
      ack_with(16'h1111);
      chk("t3_68k_valid", m68k_rom_valid, 1);
      m68k_rom_cs = 1'b0;
      step();
      chk("t3_second_z80", mem_addr, 24'h040100);
      chk("t3_second_req", mem_req, 1);
      ack_with(16'h2222);
      chk("t3_z80_byte", z80_rom_data, 8'h22);
      z80_rom_cs = 1'b0;
      step();
      m68k_a = 23'h000020; m68k_rom_cs = 1'b1;
      step(); step();
      ack_with(16'h3333);
      m68k_rom_cs = 1'b0;
      step(); step();
      m68k_a = 23'h000030; m68k_rom_cs = 1'b1;
      z80_addr = 16'h0300; z80_rom_cs = 1'b1;
      step(); step();
      chk("t3_rr_z80_first", mem_addr, 24'h040180);
      ack_with(16'h4444);
      z80_rom_cs = 1'b0;
      step();
      chk("t3_rr_68k_second", mem_addr, 24'h000030);
      ack_with(16'h5555);
      chk("t3_rr_68k_data", m68k_rom_data, 16'h5555);
      m68k_rom_cs = 1'b0;
      step();

      // ROM-2 mapping
      m68k_a = 23'h180008; m68k_rom_2_cs = 1'b1;
      step(); step();
      chk("t4_rom2_addr", mem_addr, 24'h020008);
      ack_with(16'h6666);
      chk("t4_valid", m68k_rom_valid, 1);
      m68k_rom_2_cs = 1'b0;
      step();

      // Reset in the middle of a transaction, then a late ack
      m68k_a = 23'h000040; m68k_rom_cs = 1'b1;
      step(); step();
      chk("t5_req_before", mem_req, 1);
      reset = 1'b1;
      m68k_rom_cs = 1'b0;
      step();
      reset = 1'b0;
      chk("t5_req_dropped", mem_req, 0);
      ack_with(16'h7777);
      chk("t5_no_valid", m68k_rom_valid, 0);
      chk("t5_req_idle", mem_req, 0);
      z80_addr = 16'h0300; z80_rom_cs = 1'b1;
      step();
      chk("t5_tag_invalid", z80_wait_n, 0);
      step();
      chk("t5_z80_addr", mem_addr, 24'h040180);
      ack_with(16'h8888);
      chk("t5_z80_byte", z80_rom_data, 8'h88);
      z80_rom_cs = 1'b0;
      step();

      // 68k abandons its cycle before the ack
      m68k_a = 23'h000050; m68k_rom_cs = 1'b1;
      step(); step();
      chk("t6_req", mem_req, 1);
      m68k_rom_cs = 1'b0;
      step(); step();
      chk("t6_req_held", mem_req, 1);
      chk("t6_addr_held", mem_addr, 24'h000050);
      ack_with(16'h9999);
      chk("t6_no_valid", m68k_rom_valid, 0);
      step();
      chk("t6_no_valid2", m68k_rom_valid, 0);
      m68k_a = 23'h000060; m68k_rom_cs = 1'b1;
      step(); step();
      chk("t6_next_addr", mem_addr, 24'h000060);
      ack_with(16'hAAAA);
      chk("t6_next_data", m68k_rom_data, 16'hAAAA);
      m68k_rom_cs = 1'b0;
      step();

      // Randomised concurrent traffic against the model
      resp_en = 1'b1;
      fork
         run_m68k(40);
         run_z80(60);
      join
      resp_en = 1'b0;
      step();
      mem_ack = 1'b0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
